// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out stage feeding a serial D-register chain.
// Takes a WIDTH-bit word over a valid/ready load port and emits it one bit per
// accepted transfer on a valid/ready bit port, pulsing done after the last bit.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   clear_n     synchronous clear, active-low (wins over load and shift)
//   load_valid  upstream offers load_data
//   load_ready  block is IDLE and can take a word
//   load_data   parallel word
//   bit_valid   bit_out holds a valid serial bit (state SHIFT)
//   bit_ready   downstream takes bit_out this cycle
//   bit_out     current serial bit
//   busy        word in progress (state SHIFT)
//   done        one-cycle pulse in the first IDLE cycle after the last bit
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   shreg_next;

    // The bit on the output end is dropped and a zero enters the far end,
    // so the register is all-zero once the word has been fully consumed.
    always_comb begin
        shreg_next = shreg_q;
        if (LSB_FIRST) begin
            shreg_next = shreg_q >> 1;
        end else begin
            shreg_next = shreg_q << 1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (!clear_n) begin
            // Discards any word in progress without a done pulse.
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        shreg_d = load_data;
                        cnt_d   = CNT_LAST;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_ready) begin
                        shreg_d = shreg_next;
                        if (cnt_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Output decode: state and shreg only, never bit_ready.
    always_comb begin
        load_ready = 1'b0;
        bit_valid  = 1'b0;
        busy       = 1'b0;
        bit_out    = 1'b0;
        unique case (state_q)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                bit_valid = 1'b1;
                busy      = 1'b1;
                bit_out   = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
            end
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for piso_serializer.
// Instance 0 is LSB-first, instance 1 is MSB-first, both WIDTH=8.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] clear_n;
    logic [1:0] lv;
    logic [1:0] br;
    logic [7:0] ld [2];
    wire  [1:0] lr;
    wire  [1:0] bv;
    wire  [1:0] bo;
    wire  [1:0] bsy;
    wire  [1:0] dn;

    int n_chk  = 0;
    int n_fail = 0;

    bit qb0[$];
    bit qb1[$];
    int qd [2];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk       (clk),
        .reset     (reset),
        .clear_n   (clear_n[0]),
        .load_valid(lv[0]),
        .load_ready(lr[0]),
        .load_data (ld[0]),
        .bit_valid (bv[0]),
        .bit_ready (br[0]),
        .bit_out   (bo[0]),
        .busy      (bsy[0]),
        .done      (dn[0])
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk       (clk),
        .reset     (reset),
        .clear_n   (clear_n[1]),
        .load_valid(lv[1]),
        .load_ready(lr[1]),
        .load_data (ld[1]),
        .bit_valid (bv[1]),
        .bit_ready (br[1]),
        .bit_out   (bo[1]),
        .busy      (bsy[1]),
        .done      (dn[1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? qb0.size() : qb1.size();
    endfunction

    function automatic bit qfront(input int i);
        return (i == 0) ? qb0[0] : qb1[0];
    endfunction

    task automatic qpop(input int i);
        bit b;
        if (i == 0) b = qb0.pop_front();
        else        b = qb1.pop_front();
    endtask

    task automatic qpush(input int i, input bit b);
        if (i == 0) qb0.push_back(b);
        else        qb1.push_back(b);
    endtask

    task automatic qflush(input int i);
        if (i == 0) qb0.delete();
        else        qb1.delete();
        qd[i] = 0;
    endtask

    // Monitor: compares every presented bit (held or accepted) against the
    // head of the queue, pops on acceptance, and matches done pulses.
    task automatic mon(input int i);
        if (bv[i]) begin
            chk($sformatf("bit_queued%0d", i), 32'(qsize(i) != 0), 32'd1);
            if (qsize(i) != 0) begin
                chk($sformatf("bit_out%0d", i), 32'(bo[i]), 32'(qfront(i)));
                if (br[i]) qpop(i);
            end
        end
        if (dn[i]) begin
            chk($sformatf("done_expected%0d", i), 32'(qd[i] != 0), 32'd1);
            chk($sformatf("done_idle%0d", i), 32'(bv[i]), 32'd0);
            if (qd[i] != 0) qd[i]--;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // seq: hand-written emission order, leftmost bit emitted first.
    task automatic push_seq(input int i, input logic [7:0] seq);
        for (int b = 7; b >= 0; b--) qpush(i, seq[b]);
        qd[i]++;
    endtask

    task automatic load(input int i, input logic [7:0] data,
                        input logic [7:0] seq);
        ld[i] = data;
        lv[i] = 1'b1;
        push_seq(i, seq);
        tick;
        lv[i] = 1'b0;
        chk($sformatf("load_busy%0d", i), 32'(bsy[i]), 32'd1);
    endtask

    task automatic wait_done(input int i, output int n);
        n = 0;
        while (!dn[i] && n < 40) begin
            tick;
            n++;
        end
    endtask

    task automatic chk_idle(input string nm, input int i);
        chk({nm, "_lr"},   32'(lr[i]),  32'd1);
        chk({nm, "_bv"},   32'(bv[i]),  32'd0);
        chk({nm, "_bo"},   32'(bo[i]),  32'd0);
        chk({nm, "_busy"}, 32'(bsy[i]), 32'd0);
        chk({nm, "_done"}, 32'(dn[i]),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset   = 1'b1;
        clear_n = 2'b11;
        lv      = 2'b00;
        br      = 2'b00;
        ld[0]   = 8'h00;
        ld[1]   = 8'h00;
        qd[0]   = 0;
        qd[1]   = 0;
        #1;
        chk_idle("rst0", 0);
        chk_idle("rst1", 1);
        repeat (2) tick;
        reset = 1'b0;
        tick;

        // LSB-first A5, continuous ready, done latency
        br[0] = 1'b1;
        load(0, 8'hA5, 8'b1010_0101);
        wait_done(0, n);
        chk("t2_done_lat", 32'(n), 32'd8);
        chk("t2_done_lr", 32'(lr[0]), 32'd1);
        tick;
        chk("t2_done_pulse", 32'(dn[0]), 32'd0);
        br[0] = 1'b0;

        // MSB-first A5, ready toggling, each bit stalled once
        br[1] = 1'b1;
        load(1, 8'hA5, 8'b1010_0101);
        n = 0;
        while (!dn[1] && n < 40) begin
            br[1] = ~br[1];
            tick;
            n++;
        end
        chk("t3_done_lat", 32'(n), 32'd16);
        br[1] = 1'b0;
        tick;

        // clear_n mid-word, then a fresh word
        br[0] = 1'b1;
        load(0, 8'hFF, 8'b1111_1111);
        repeat (3) tick;
        br[0]      = 1'b0;
        clear_n[0] = 1'b0;
        tick;
        clear_n[0] = 1'b1;
        chk("t4_clr_bv", 32'(bv[0]), 32'd0);
        chk("t4_clr_busy", 32'(bsy[0]), 32'd0);
        chk("t4_clr_lr", 32'(lr[0]), 32'd1);
        chk("t4_clr_done", 32'(dn[0]), 32'd0);
        qflush(0);
        repeat (3) tick;
        br[0] = 1'b1;
        load(0, 8'h01, 8'b1000_0000);
        wait_done(0, n);
        chk("t4_done_lat", 32'(n), 32'd8);
        tick;

        // back-to-back words with load_valid held
        ld[0] = 8'h3C;
        lv[0] = 1'b1;
        push_seq(0, 8'b0011_1100);
        push_seq(0, 8'b1100_0011);
        tick;
        ld[0] = 8'hC3;
        chk("t5_busy1", 32'(bsy[0]), 32'd1);
        n = 0;
        while (!lr[0] && n < 40) begin
            tick;
            n++;
        end
        chk("t5_gap_lat", 32'(n), 32'd8);
        chk("t5_gap_done", 32'(dn[0]), 32'd1);
        chk("t5_gap_bv", 32'(bv[0]), 32'd0);
        tick;
        lv[0] = 1'b0;
        chk("t5_busy2", 32'(bsy[0]), 32'd1);
        wait_done(0, n);
        chk("t5_done_lat", 32'(n), 32'd8);
        br[0] = 1'b0;
        tick;

        // load_valid pulsed during SHIFT is ignored
        br[1] = 1'b1;
        load(1, 8'hF0, 8'b1111_0000);
        tick;
        ld[1] = 8'h00;
        lv[1] = 1'b1;
        tick;
        lv[1] = 1'b0;
        wait_done(1, n);
        chk("t6_done_lat", 32'(n), 32'd6);
        repeat (2) tick;
        chk("t6_idle_busy", 32'(bsy[1]), 32'd0);
        br[1] = 1'b0;

        // async reset mid-word: outputs drop before any clock edge
        br[0] = 1'b1;
        load(0, 8'hFF, 8'b1111_1111);
        repeat (3) tick;
        chk("t1_pre_bo", 32'(bo[0]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("t1_async", 0);
        qflush(0);
        br[0] = 1'b0;
        tick;
        reset = 1'b0;
        tick;
        chk_idle("t1_post", 0);

        chk("end_q0", 32'(qb0.size()), 32'd0);
        chk("end_q1", 32'(qb1.size()), 32'd0);
        chk("end_d0", 32'(qd[0]), 32'd0);
        chk("end_d1", 32'(qd[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
